adder_pipe_nbit: RTL

//  Parametrised pipelined ripple-carry adder: {overflow,sum} = a + b + carry_in, unsigned.

---
 rtl/adder_pipe_pkg.sv | 17 +
 rtl/adder_pipe_stage.sv | 41 ++++
 rtl/adder_pipe_nbit.sv | 118 +++++++++++
 3 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined ripple-carry adder.
package adder_pipe_pkg;

  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_STAGES    = 4;

  // Per-rank control record; the partial sum sits beside it because its width is per instance.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int chunk_w(input int bit_width, input int stages);
    return bit_width / stages;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline rank: CHUNK_W-bit ripple add of a chunk plus incoming carry, registered with hold.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               en,
  input  logic               vld_i,
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic               vld_q,
  output logic               cout_q,
  output logic [CHUNK_W-1:0] psum_q
);

  stage_ctl_t       ctl_q;
  logic [CHUNK_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};

  // Data only moves for valid transactions so the output holds across bubbles.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ctl_q  <= '0;
      psum_q <= '0;
    end else if (en) begin
      ctl_q.valid <= vld_i;
      if (vld_i) begin
        ctl_q.carry <= full[CHUNK_W];
        psum_q      <= full[CHUNK_W-1:0];
      end
    end
  end

  assign vld_q  = ctl_q.valid;
  assign cout_q = ctl_q.carry;

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined unsigned adder {overflow,sum} = a + b + carry_in, STAGES ranks with valid/ready.
// Define ADDER_PIPE_ASSERT_EN to compile in simulation-only input and result checks.
module adder_pipe_nbit
  import adder_pipe_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int STAGES    = DEF_STAGES
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 valid_in,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic                 valid_out,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  localparam int CW = chunk_w(BIT_WIDTH, STAGES);

  logic [STAGES:0] vld_pipe;
  logic            stall;
  logic            en;

  assign vld_pipe[0] = valid_in;
  assign valid_out   = vld_pipe[STAGES];
  assign stall       = valid_out & ~out_ready;
  assign in_ready    = ~stall;
  assign en          = ~stall;

  // Rank k sees operand chunks k.. right-aligned in opa/opb and carries sum chunks 0..k in acc.
  for (genvar k = 0; k < STAGES; k++) begin : g_rank
    logic [(STAGES-k)*CW-1:0] opa;
    logic [(STAGES-k)*CW-1:0] opb;
    logic                     cin;
    logic                     cout;
    logic [CW-1:0]            psum;
    logic [(k+1)*CW-1:0]      acc;

    if (k == 0) begin : g_first
      assign opa = a;
      assign opb = b;
      assign cin = carry_in;
      assign acc = psum;
    end else begin : g_next
      logic [k*CW-1:0] lo;

      // Skew: upper operand chunks advance alongside the previous rank.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          opa <= '0;
          opb <= '0;
        end else if (en && vld_pipe[k-1]) begin
          opa <= g_rank[k-1].opa[(STAGES-k+1)*CW-1:CW];
          opb <= g_rank[k-1].opb[(STAGES-k+1)*CW-1:CW];
        end
      end

      // De-skew: finished low chunks travel with this rank's result.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          lo <= '0;
        end else if (en && vld_pipe[k]) begin
          lo <= g_rank[k-1].acc;
        end
      end

      assign cin = g_rank[k-1].cout;
      assign acc = {psum, lo};
    end

    adder_pipe_stage #(.CHUNK_W(CW)) u_stage (
      .clk    (clk),
      .n_rst  (n_rst),
      .en     (en),
      .vld_i  (vld_pipe[k]),
      .a      (opa[CW-1:0]),
      .b      (opb[CW-1:0]),
      .cin    (cin),
      .vld_q  (vld_pipe[k+1]),
      .cout_q (cout),
      .psum_q (psum)
    );
  end

  assign sum      = g_rank[STAGES-1].acc;
  assign overflow = g_rank[STAGES-1].cout;

`ifdef ADDER_PIPE_ASSERT_EN
  if (BIT_WIDTH % STAGES != 0) begin : g_bad_cfg
    $fatal(1, "BIT_WIDTH must be a multiple of STAGES");
  end

  logic [BIT_WIDTH:0] gold_q[$];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gold_q.delete();
    end else begin
      if (valid_in && $isunknown({a, b, carry_in}))
        $error("input not a digital logic value");
      if (valid_out && out_ready) begin
        if (gold_q.size() == 0 || {overflow, sum} !== gold_q[0])
          $error("result differs from golden model");
        if (gold_q.size() != 0) void'(gold_q.pop_front());
      end
      if (valid_in && in_ready)
        gold_q.push_back({1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in});
    end
  end
`else
  // Checks compiled out; the synthesised datapath is the same.
`endif

endmodule
